// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared types and constants for the fetch/decode front end:
//            datapath width, canonical NOP, the fetch buffer entry layout and
//            the base opcode map used by decode.
// Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  // One buffered fetch: the instruction word and the PC it was read from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b000_0011,
    OPC_OP_IMM = 7'b001_0011,
    OPC_AUIPC  = 7'b001_0111,
    OPC_STORE  = 7'b010_0011,
    OPC_OP     = 7'b011_0011,
    OPC_LUI    = 7'b011_0111,
    OPC_BRANCH = 7'b110_0011,
    OPC_JALR   = 7'b110_0111,
    OPC_JAL    = 7'b110_1111,
    OPC_SYSTEM = 7'b111_0011
  } opcode_e;

  function automatic opcode_e get_opcode(input logic [XLEN-1:0] instr);
    return opcode_e'(instr[6:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small synchronous FIFO with flush. Storage is registered, so the
//            head is visible the cycle after the push. Push and pop together
//            on a full FIFO is legal. Pops on an empty FIFO are ignored.
// Ports    : clk, rst_n         clock, asynchronous active-low reset
//            flush              empties the FIFO; overrides push and pop
//            push, push_data    write one entry
//            pop                remove the head entry
//            head               current head entry
//            count              number of valid entries
// Revision : 1.0  initial release
// ============================================================================
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int C_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int C_CW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [C_CW-1:0]  count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]  r_wr_ptr;
  logic [C_AW-1:0]  r_rd_ptr;
  logic [C_CW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [C_AW-1:0] ptr_inc(input logic [C_AW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + C_AW'(1);
  endfunction

  assign w_push = push && !flush;
  assign w_pop  = pop && !flush && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CW'(1);
        2'b01:   r_count <= r_count - C_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch. Holds the PC, issues word reads to imem under
//            a credit limit, buffers responses and presents {instr, pc} to
//            decode. EX redirects flush the buffer and squash in-flight reads.
// Ports    : clk, rst_n                         clock, async active-low reset
//            imem_req/addr/gnt/rvalid/rdata     instruction memory interface
//            redirect_valid, redirect_pc        control-flow change from EX
//            id_valid/ready/instr/pc            handshake toward decode
//            fetch_cnt, squash_cnt              statistics (IFETCH_STAT_EN)
// Config   : `define IFETCH_STAT_EN adds the delivered/squashed counters.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2,
  parameter int              MAX_OUTST  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
`ifdef IFETCH_STAT_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     squash_cnt
`endif
);

  localparam int C_OW = $clog2(MAX_OUTST + 1);
  localparam int C_FW = $clog2(FIFO_DEPTH + 1);
  localparam int C_EW = $bits(fetch_entry_t);

  logic [XLEN-1:0] r_pc;
  logic [C_OW-1:0] r_drop;
  logic            r_active;
  logic [C_OW-1:0] w_outst;
  logic [C_FW-1:0] w_fcnt;
  logic [C_EW-1:0] w_head_raw;
  fetch_entry_t    w_head;
  fetch_entry_t    w_entry;
  logic [XLEN-1:0] w_rsp_pc;
  logic            w_grant;
  logic            w_rsp_keep;
  logic            w_pop;
  logic            w_unused;

  // Low address bits of a redirect target are discarded.
  assign w_unused = ^redirect_pc[1:0];

  assign w_grant    = imem_req && imem_gnt;
  assign w_rsp_keep = imem_rvalid && (r_drop == '0) && !redirect_valid;
  assign w_pop      = id_valid && id_ready;
  assign w_entry    = '{instr: imem_rdata, pc: w_rsp_pc};

  // Credits count buffered plus in-flight words so every response has a slot.
  // r_active holds requests off until the first clock after reset release.
  assign imem_req  = r_active && !redirect_valid
                  && ((32'(w_outst) + 32'(w_fcnt)) < 32'(FIFO_DEPTH))
                  && (32'(w_outst) < 32'(MAX_OUTST));
  assign imem_addr = r_pc;

  // PC queue: never flushed, so it stays paired with every response,
  // including squashed ones. Its occupancy is the outstanding-read count.
  fetch_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (XLEN)
  ) u_pc_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (w_grant),
    .push_data (r_pc),
    .pop       (imem_rvalid),
    .head      (w_rsp_pc),
    .count     (w_outst)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (C_EW)
  ) u_instr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (w_rsp_keep),
    .push_data (w_entry),
    .pop       (w_pop),
    .head      (w_head_raw),
    .count     (w_fcnt)
  );

  assign w_head   = fetch_entry_t'(w_head_raw);
  assign id_valid = (w_fcnt != '0);
  assign id_instr = w_head.instr;
  assign id_pc    = w_head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_drop   <= '0;
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (redirect_valid) begin
        r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        // Everything still in flight after this cycle belongs to the old path.
        r_drop <= w_outst - C_OW'(imem_rvalid);
      end else begin
        if (w_grant) r_pc <= r_pc + 32'd4;
        if (imem_rvalid && (r_drop != '0)) r_drop <= r_drop - C_OW'(1);
      end
    end
  end

`ifdef IFETCH_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (w_pop && !redirect_valid) fetch_cnt <= fetch_cnt + 32'd1;
      if (imem_rvalid && ((r_drop != '0) || redirect_valid))
        squash_cnt <= squash_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
